// File: rtl/alu_seq_ctrl.sv
// Operand-entry and execution sequencer for the shared 4-bit add/sub ALU.
// Latches A, then B/select, runs one EXEC cycle, and holds a signed-magnitude result in SHOW.
module alu_seq_ctrl #(
    parameter int unsigned HOLD_TICKS = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] sw,
    input  logic       sel_in,
    input  logic [3:0] alu_so,
    input  logic       alu_flag,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_sel,
    output logic [4:0] result_val,
    output logic       result_neg,
    output logic       result_valid,
    output logic       busy,
    output logic [1:0] state
);

    localparam int unsigned CW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((HOLD_TICKS == 0) ? 0 : HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_B = 2'd1,
        EXEC   = 2'd2,
        SHOW   = 2'd3
    } state_t;

    state_t        cur_state, nxt_state;
    logic [CW-1:0] hold_cnt;
    logic          ld_a, ld_b, capture, cnt_clr, cnt_inc;
    logic          carry_pos, borrow_neg;
    logic [3:0]    magnitude;

    always_comb begin
        nxt_state = cur_state;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        capture   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (cur_state)
            IDLE: begin
                if (load) begin
                    ld_a      = 1'b1;
                    nxt_state = WAIT_B;
                end
            end
            WAIT_B: begin
                if (load) begin
                    ld_b      = 1'b1;
                    nxt_state = EXEC;
                end
            end
            EXEC: begin
                capture   = 1'b1;
                cnt_clr   = 1'b1;
                nxt_state = SHOW;
            end
            SHOW: begin
                // load wins over tick; HOLD_TICKS == 0 means hold until the next load
                if (load) begin
                    ld_a      = 1'b1;
                    cnt_clr   = 1'b1;
                    nxt_state = WAIT_B;
                end else if (tick && (HOLD_TICKS != 0)) begin
                    if (hold_cnt == LAST) begin
                        cnt_clr   = 1'b1;
                        nxt_state = IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        carry_pos  = ~alu_sel & alu_flag;
        borrow_neg = alu_sel & alu_flag;
        magnitude  = borrow_neg ? (~alu_so + 4'd1) : alu_so;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state  <= IDLE;
            hold_cnt   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= 1'b0;
            result_val <= '0;
            result_neg <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            if (ld_a) alu_a <= sw;
            if (ld_b) begin
                alu_b   <= sw;
                alu_sel <= sel_in;
            end
            if (capture) begin
                result_val <= {carry_pos, magnitude};
                result_neg <= borrow_neg;
            end
            if (cnt_clr)      hold_cnt <= '0;
            else if (cnt_inc) hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign state        = cur_state;
    assign result_valid = (cur_state == SHOW);
    assign busy         = (cur_state == WAIT_B) || (cur_state == EXEC);

endmodule
